// File: rtl/tlul_pkg.sv
// TL-UL channel types: A/D opcodes and the host-to-device / device-to-host
// channel structs used on a single TL-UL port.
package tlul_pkg;

    import top_pkg::*;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                  a_valid;
        tl_a_op_e              a_opcode;
        logic [2:0]            a_param;
        logic [TL_SZW-1:0]     a_size;
        logic [TL_AIW-1:0]     a_source;
        logic [TL_AW-1:0]      a_address;
        logic [TL_DBW-1:0]     a_mask;
        logic [TL_DW-1:0]      a_data;
        logic                  d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                  d_valid;
        tl_d_op_e              d_opcode;
        logic [2:0]            d_param;
        logic [TL_SZW-1:0]     d_size;
        logic [TL_AIW-1:0]     d_source;
        logic [TL_DIW-1:0]     d_sink;
        logic [TL_DW-1:0]      d_data;
        logic [TL_DUW-1:0]     d_user;
        logic                  d_error;
        logic                  a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_reg_bridge_pkg.sv
// Shared constants and helpers for the TL-UL register bridge and its
// request checker: default parameter values, the largest legal a_size,
// a byte-lane popcount and the lane mask addressed by (size, address[1:0]).
package tlul_reg_bridge_pkg;

    import top_pkg::*;

    localparam int                RegAwDefault         = 8;
    localparam int                TimeoutCyclesDefault = 16;
    localparam logic [TL_DW-1:0]  ErrRdataDefault      = 32'hFFFF_FFFF;

    // Largest legal a_size: one full data beat.
    localparam int TL_SZ_MAX = $clog2(TL_DBW);
    // Width of a byte-lane count (0..TL_DBW).
    localparam int TL_CNTW   = $clog2(TL_DBW) + 1;

    // Number of set byte enables.
    function automatic logic [TL_CNTW-1:0] popcount(input logic [TL_DBW-1:0] v);
        logic [TL_CNTW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < TL_DBW; i++) begin
            cnt = cnt + {{(TL_CNTW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Byte lanes covered by an access of 2**size bytes starting at addr_lo.
    function automatic logic [TL_DBW-1:0] lane_mask(input logic [TL_SZW-1:0] size,
                                                    input logic [1:0]        addr_lo);
        logic [TL_DBW-1:0] base;
        case (size)
            2'd0:    base = TL_DBW'(4'b0001);
            2'd1:    base = TL_DBW'(4'b0011);
            2'd2:    base = TL_DBW'(4'b1111);
            default: base = '0;
        endcase
        return base << addr_lo;
    endfunction

endpackage

// File: rtl/top_pkg.sv
// Global TL-UL bus dimensions shared by every endpoint in this slice.
//   TL_AW  : A-channel address width
//   TL_DW  : data width, TL_DBW : byte lanes per beat
//   TL_AIW : source id width, TL_DIW : sink id width, TL_DUW : d_user width
//   TL_SZW : width of the a_size / d_size fields
package top_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DUW = 16;
    // Enough bits to encode log2(TL_DBW) plus the out-of-range sizes.
    localparam int TL_SZW = 2;

endpackage

// File: rtl/tlul_reg_bridge_chk.sv
// Combinational legality check for a TL-UL A-channel request. Reusable by
// any TL-UL endpoint that supports Get / PutFullData / PutPartialData.
// Ports:
//   i_opcode  : a_opcode
//   i_size    : a_size (log2 of byte count)
//   i_addr_lo : a_address[1:0]
//   i_mask    : a_mask
//   o_err     : 1 when the request is malformed
module tlul_reg_bridge_chk
    import top_pkg::*;
    import tlul_pkg::*;
    import tlul_reg_bridge_pkg::*;
(
    input  tl_a_op_e          i_opcode,
    input  logic [TL_SZW-1:0] i_size,
    input  logic [1:0]        i_addr_lo,
    input  logic [TL_DBW-1:0] i_mask,
    output logic              o_err
);

    logic [TL_DBW-1:0] w_lanes;
    logic [1:0]        w_align_mask;
    logic              w_op_err;
    logic              w_size_err;
    logic              w_align_err;
    logic              w_full_err;
    logic              w_lane_err;
    logic              w_zero_err;

    // Evaluate every malformed-request condition and OR them together.
    always_comb begin
        w_lanes      = lane_mask(i_size, i_addr_lo);
        w_align_mask = 2'b11;
        w_op_err     = 1'b1;

        case (i_opcode)
            Get, PutFullData, PutPartialData: w_op_err = 1'b0;
            default:                          w_op_err = 1'b1;
        endcase

        // Low address bits that must be zero for a naturally aligned access.
        case (i_size)
            2'd0:    w_align_mask = 2'b00;
            2'd1:    w_align_mask = 2'b01;
            2'd2:    w_align_mask = 2'b11;
            default: w_align_mask = 2'b11;
        endcase

        w_size_err  = (i_size > TL_SZW'(TL_SZ_MAX));
        w_align_err = |(i_addr_lo & w_align_mask);
        // A full write must enable exactly 2**size bytes.
        w_full_err  = (i_opcode == PutFullData) &&
                      (popcount(i_mask) != (TL_CNTW'(1) << i_size));
        w_lane_err  = |(i_mask & ~w_lanes);
        w_zero_err  = ((i_opcode == Get) || (i_opcode == PutPartialData)) &&
                      (i_mask == '0);

        if (w_op_err || w_size_err || w_align_err || w_full_err || w_lane_err || w_zero_err) begin
            o_err = 1'b1;
        end else begin
            o_err = 1'b0;
        end
    end

endmodule

// File: rtl/tlul_reg_bridge.sv
// TL-UL device-side bridge to a simple register req/gnt/rvalid interface.
// One transaction outstanding at a time; malformed requests and register
// timeouts are answered with d_error. All outputs are registered.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   tl_i / tl_o        : TL-UL host-to-device / device-to-host channels
//   reg_req_o          : register request, held until reg_gnt_i
//   reg_we_o           : 1 = write, 0 = read
//   reg_addr_o         : a_address[RegAw-1:0]
//   reg_wdata_o        : write data, reg_be_o : byte enables (a_mask)
//   reg_rvalid_i       : one response per grant, with reg_rdata_i / reg_err_i
module tlul_reg_bridge
    import top_pkg::*;
    import tlul_pkg::*;
    import tlul_reg_bridge_pkg::*;
#(
    parameter int                RegAw         = RegAwDefault,
    parameter int                TimeoutCycles = TimeoutCyclesDefault,
    parameter logic [TL_DW-1:0]  ErrRdata      = ErrRdataDefault
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              reg_req_o,
    input  logic              reg_gnt_i,
    output logic              reg_we_o,
    output logic [RegAw-1:0]  reg_addr_o,
    output logic [TL_DW-1:0]  reg_wdata_o,
    output logic [TL_DBW-1:0] reg_be_o,
    input  logic              reg_rvalid_i,
    input  logic [TL_DW-1:0]  reg_rdata_i,
    input  logic              reg_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } bridge_state_e;

    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

    bridge_state_e     r_state;
    logic              r_a_ready;
    tl_a_op_e          r_op;
    logic [TL_SZW-1:0] r_size;
    logic [TL_AIW-1:0] r_source;
    logic              r_reg_req;
    logic              r_we;
    logic [RegAw-1:0]  r_addr;
    logic [TL_DW-1:0]  r_wdata;
    logic [TL_DBW-1:0] r_be;
    logic [7:0]        r_cnt;
    // A timed-out request still owes one rvalid; it must be swallowed.
    logic              r_stale;
    logic              r_d_valid;
    tl_d_op_e          r_d_opcode;
    logic [TL_DW-1:0]  r_d_data;
    logic              r_d_error;

    logic              w_chk_err;
    logic              w_a_fire;
    logic              w_unused_tl;

    tlul_reg_bridge_chk u_chk (
        .i_opcode  (tl_i.a_opcode),
        .i_size    (tl_i.a_size),
        .i_addr_lo (tl_i.a_address[1:0]),
        .i_mask    (tl_i.a_mask),
        .o_err     (w_chk_err)
    );

    assign w_a_fire    = r_a_ready && tl_i.a_valid;
    // a_param and address bits above RegAw carry no meaning here.
    assign w_unused_tl = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:RegAw]};

    // Bridge FSM: accepts A, drives the register side, builds the D response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_a_ready  <= 1'b0;
            r_op       <= PutFullData;
            r_size     <= '0;
            r_source   <= '0;
            r_reg_req  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_cnt      <= 8'd0;
            r_stale    <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= AccessAck;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else begin
            // The owed response may show up in any state; it only clears
            // the flag. A timeout below re-arms it for the new request.
            if (reg_rvalid_i && r_stale) begin
                r_stale <= 1'b0;
            end else begin
                r_stale <= r_stale;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_a_fire) begin
                        r_a_ready  <= 1'b0;
                        r_op       <= tl_i.a_opcode;
                        r_size     <= tl_i.a_size;
                        r_source   <= tl_i.a_source;
                        r_d_opcode <= (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
                        if (w_chk_err) begin
                            r_state   <= ST_RSP;
                            r_d_valid <= 1'b1;
                            r_d_error <= 1'b1;
                            r_d_data  <= (tl_i.a_opcode == Get) ? ErrRdata : '0;
                        end else begin
                            r_state   <= ST_REQ;
                            r_reg_req <= 1'b1;
                            r_we      <= (tl_i.a_opcode != Get);
                            r_addr    <= tl_i.a_address[RegAw-1:0];
                            r_wdata   <= tl_i.a_data;
                            r_be      <= tl_i.a_mask;
                        end
                    end else begin
                        r_a_ready <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (reg_gnt_i) begin
                        r_reg_req <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= ST_WAIT;
                    end else begin
                        r_reg_req <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (reg_rvalid_i && !r_stale) begin
                        r_state   <= ST_RSP;
                        r_d_valid <= 1'b1;
                        r_d_error <= reg_err_i;
                        if (r_op == Get) begin
                            r_d_data <= reg_err_i ? ErrRdata : reg_rdata_i;
                        end else begin
                            r_d_data <= '0;
                        end
                    end else if (r_cnt == TimeoutLast) begin
                        r_stale   <= 1'b1;
                        r_state   <= ST_RSP;
                        r_d_valid <= 1'b1;
                        r_d_error <= 1'b1;
                        r_d_data  <= (r_op == Get) ? ErrRdata : '0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_RSP: begin
                    if (tl_i.d_ready) begin
                        r_d_valid <= 1'b0;
                        r_a_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_d_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_reg_req <= 1'b0;
                    r_d_valid <= 1'b0;
                    r_a_ready <= 1'b0;
                end
            endcase
        end
    end

    // Pack registered response fields onto the D channel.
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = r_d_valid;
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_size   = r_size;
        tl_o.d_source = r_source;
        tl_o.d_data   = r_d_data;
        tl_o.d_error  = r_d_error;
        tl_o.a_ready  = r_a_ready;
    end

    assign reg_req_o   = r_reg_req;
    assign reg_we_o    = r_we;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_be_o    = r_be;

endmodule

// File: tb/tb_tlul_reg_bridge.sv
// Directed + randomized bench for tlul_reg_bridge. Expected results come
// from a behavioural model of the request rules and response format.
module tb_tlul_reg_bridge;

    import top_pkg::*;
    import tlul_pkg::*;

    localparam int TO = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    tl_h2d_t           tl_i;
    tl_d2h_t           tl_o;
    logic              reg_req_o;
    logic              reg_gnt_i;
    logic              reg_we_o;
    logic [7:0]        reg_addr_o;
    logic [TL_DW-1:0]  reg_wdata_o;
    logic [TL_DBW-1:0] reg_be_o;
    logic              reg_rvalid_i;
    logic [TL_DW-1:0]  reg_rdata_i;
    logic              reg_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    tlul_reg_bridge #(
        .RegAw         (8),
        .TimeoutCycles (TO),
        .ErrRdata      (32'hFFFF_FFFF)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tl_i         (tl_i),
        .tl_o         (tl_o),
        .reg_req_o    (reg_req_o),
        .reg_gnt_i    (reg_gnt_i),
        .reg_we_o     (reg_we_o),
        .reg_addr_o   (reg_addr_o),
        .reg_wdata_o  (reg_wdata_o),
        .reg_be_o     (reg_be_o),
        .reg_rvalid_i (reg_rvalid_i),
        .reg_rdata_i  (reg_rdata_i),
        .reg_err_i    (reg_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request legality straight from the protocol rules, using byte counts.
    function automatic bit model_err(input logic [2:0] op, input logic [1:0] size,
                                     input logic [31:0] addr, input logic [3:0] mask);
        int nbytes = 1 << size;
        int lo     = int'(addr[1:0]);
        int pc     = 0;
        bit e      = 1'b0;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) e = 1'b1;
        if (size > 2) e = 1'b1;
        if ((lo % nbytes) != 0) e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                pc++;
                if (!(i >= lo && i < lo + nbytes)) e = 1'b1;
            end
        end
        if (op == 3'd0 && pc != nbytes) e = 1'b1;
        if ((op == 3'd4 || op == 3'd1) && mask == 4'd0) e = 1'b1;
        return e;
    endfunction

    // One full transaction. rv_dly < 0 withholds rvalid (timeout expected);
    // junk=1 presents a leftover rvalid first, which must be discarded.
    task automatic txn(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic rerr, input bit junk, input int dready_dly);
        bit          exp_chk;
        bit          timeout;
        bit          exp_e;
        logic [31:0] exp_data;
        int          waited;
        exp_chk = model_err(op, size, addr, mask);
        timeout = !exp_chk && (rv_dly < 0);
        exp_e   = exp_chk || timeout || rerr;
        exp_data = (op == 3'd4) ? (exp_e ? 32'hFFFF_FFFF : rdata) : 32'h0;

        @(negedge clk_i);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_param   = 3'($urandom_range(0, 7));
        tl_i.a_size    = size;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        waited = 0;
        while (tl_o.a_ready !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        chk("a_ready_wait", {31'd0, tl_o.a_ready}, 32'd1);
        @(negedge clk_i);
        tl_i.a_valid = 1'b0;

        if (exp_chk) begin
            chk("err_no_req", {31'd0, reg_req_o}, 32'd0);
        end else begin
            chk("req", {31'd0, reg_req_o}, 32'd1);
            chk("req_dvalid_low", {31'd0, tl_o.d_valid}, 32'd0);
            chk("we", {31'd0, reg_we_o}, {31'd0, op != 3'd4});
            chk("addr", {24'd0, reg_addr_o}, {24'd0, addr[7:0]});
            chk("be", {28'd0, reg_be_o}, {28'd0, mask});
            chk("wdata", reg_wdata_o, data);
            for (int i = 0; i < gnt_dly; i++) begin
                @(negedge clk_i);
                chk("req_held", {31'd0, reg_req_o}, 32'd1);
                chk("be_held", {28'd0, reg_be_o}, {28'd0, mask});
            end
            reg_gnt_i = 1'b1;
            @(negedge clk_i);
            reg_gnt_i = 1'b0;
            chk("req_drop", {31'd0, reg_req_o}, 32'd0);
            if (timeout) begin
                repeat (TO - 1) @(negedge clk_i);
                chk("to_not_yet", {31'd0, tl_o.d_valid}, 32'd0);
                @(negedge clk_i);
            end else begin
                if (junk) begin
                    reg_rvalid_i = 1'b1;
                    reg_rdata_i  = 32'hDEAD_BEEF;
                    reg_err_i    = 1'b1;
                    @(negedge clk_i);
                    reg_rvalid_i = 1'b0;
                    reg_err_i    = 1'b0;
                    chk("junk_dropped", {31'd0, tl_o.d_valid}, 32'd0);
                end
                for (int i = 0; i < rv_dly; i++) begin
                    @(negedge clk_i);
                    chk("no_early_dvalid", {31'd0, tl_o.d_valid}, 32'd0);
                end
                reg_rvalid_i = 1'b1;
                reg_rdata_i  = rdata;
                reg_err_i    = rerr;
                @(negedge clk_i);
                reg_rvalid_i = 1'b0;
                reg_err_i    = 1'b0;
                reg_rdata_i  = 32'h0;
            end
        end

        chk("d_valid", {31'd0, tl_o.d_valid}, 32'd1);
        chk("d_opcode", {29'd0, tl_o.d_opcode}, (op == 3'd4) ? 32'd1 : 32'd0);
        chk("d_error", {31'd0, tl_o.d_error}, {31'd0, exp_e});
        chk("d_data", tl_o.d_data, exp_data);
        chk("d_size", {30'd0, tl_o.d_size}, {30'd0, size});
        chk("d_source", {24'd0, tl_o.d_source}, {24'd0, src});
        chk("rsp_a_ready", {31'd0, tl_o.a_ready}, 32'd0);
        tl_i.d_ready = 1'b0;
        for (int i = 0; i < dready_dly; i++) begin
            @(negedge clk_i);
            chk("hold_d_valid", {31'd0, tl_o.d_valid}, 32'd1);
            chk("hold_d_data", tl_o.d_data, exp_data);
            chk("hold_d_error", {31'd0, tl_o.d_error}, {31'd0, exp_e});
            chk("hold_d_source", {24'd0, tl_o.d_source}, {24'd0, src});
            chk("hold_a_ready", {31'd0, tl_o.a_ready}, 32'd0);
        end
        tl_i.d_ready = 1'b1;
        @(negedge clk_i);
        tl_i.d_ready = 1'b0;
        chk("d_done", {31'd0, tl_o.d_valid}, 32'd0);
        chk("a_ready_back", {31'd0, tl_o.a_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [3:0]  lanes;
        int          nbytes;
        int          lo;

        tl_i         = '0;
        rst_i        = 1'b1;
        reg_gnt_i    = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = 32'h0;
        reg_err_i    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_a_ready", {31'd0, tl_o.a_ready}, 32'd0);
        chk("rst_d_valid", {31'd0, tl_o.d_valid}, 32'd0);
        chk("rst_d_data", tl_o.d_data, 32'd0);
        chk("rst_d_error", {31'd0, tl_o.d_error}, 32'd0);
        chk("rst_req", {31'd0, reg_req_o}, 32'd0);
        chk("rst_we", {31'd0, reg_we_o}, 32'd0);
        chk("rst_addr", {24'd0, reg_addr_o}, 32'd0);
        chk("rst_wdata", reg_wdata_o, 32'd0);
        chk("rst_be", {28'd0, reg_be_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_a_ready", {31'd0, tl_o.a_ready}, 32'd1);

        // Get, immediate grant and rvalid: minimum latency
        txn(3'd4, 2'd2, 32'h0000_0010, 4'hF, 32'h0, 8'd3, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 0);
        // PutPartialData with delayed grant
        txn(3'd1, 2'd1, 32'h0000_0006, 4'hC, 32'hAB12_0000, 8'd5, 4, 1, 32'h0, 1'b0, 1'b0, 1);
        // PutFullData with short mask
        txn(3'd0, 2'd2, 32'h0000_0000, 4'h7, 32'h1111_2222, 8'd7, 0, 0, 32'h0, 1'b0, 1'b0, 0);
        // Misaligned Get
        txn(3'd4, 2'd2, 32'h0000_0002, 4'hF, 32'h0, 8'd9, 0, 0, 32'h0, 1'b0, 1'b0, 0);
        // Timeout, late rvalid in IDLE, then a clean Get
        txn(3'd4, 2'd2, 32'h0000_0020, 4'hF, 32'h0, 8'd1, 0, -1, 32'h0, 1'b0, 1'b0, 0);
        @(negedge clk_i);
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'h0BAD_0BAD;
        @(negedge clk_i);
        reg_rvalid_i = 1'b0;
        chk("late_rvalid_no_dvalid", {31'd0, tl_o.d_valid}, 32'd0);
        chk("late_rvalid_a_ready", {31'd0, tl_o.a_ready}, 32'd1);
        txn(3'd4, 2'd2, 32'h0000_0024, 4'hF, 32'h0, 8'd2, 0, 2, 32'h0000_0005, 1'b0, 1'b0, 0);
        // Timeout, late rvalid lands in the next request's wait
        txn(3'd4, 2'd2, 32'h0000_0028, 4'hF, 32'h0, 8'd4, 1, -1, 32'h0, 1'b0, 1'b0, 0);
        txn(3'd4, 2'd0, 32'h0000_0029, 4'h2, 32'h0, 8'd6, 0, 0, 32'h0000_1234, 1'b0, 1'b1, 0);
        // Register-side error with d_ready held low for 5 cycles
        txn(3'd4, 2'd2, 32'h0000_0040, 4'hF, 32'h0, 8'd8, 2, 3, 32'h5555_AAAA, 1'b1, 1'b0, 5);
        // Write errored by the register side
        txn(3'd0, 2'd1, 32'h0000_0042, 4'hC, 32'h7777_0000, 8'd10, 0, 1, 32'h0, 1'b1, 1'b0, 0);

        // Randomized mix of legal and arbitrary requests
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                op   = 3'($urandom_range(0, 7));
                size = 2'($urandom_range(0, 3));
                addr = $urandom;
                mask = 4'($urandom);
            end else begin
                size   = 2'($urandom_range(0, 2));
                nbytes = 1 << size;
                lo     = ($urandom_range(0, 3) / nbytes) * nbytes;
                addr   = $urandom;
                addr[1:0] = 2'(lo);
                lanes  = 4'(((1 << nbytes) - 1) << lo);
                case ($urandom_range(0, 2))
                    0:       op = 3'd4;
                    1:       op = 3'd0;
                    default: op = 3'd1;
                endcase
                mask = (op == 3'd0) ? lanes : (lanes & 4'($urandom));
                if (mask == 4'd0) mask = lanes;
            end
            txn(op, size, addr, mask, $urandom, 8'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0), 1'b0,
                $urandom_range(0, 2));
        end

        // Reset pulsed while waiting for the register response
        @(negedge clk_i);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = Get;
        tl_i.a_size    = 2'd2;
        tl_i.a_address = 32'h0000_0030;
        tl_i.a_mask    = 4'hF;
        @(negedge clk_i);
        tl_i.a_valid = 1'b0;
        chk("rstw_req", {31'd0, reg_req_o}, 32'd1);
        reg_gnt_i = 1'b1;
        @(negedge clk_i);
        reg_gnt_i = 1'b0;
        rst_i     = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rstw_d_valid", {31'd0, tl_o.d_valid}, 32'd0);
        chk("rstw_a_ready", {31'd0, tl_o.a_ready}, 32'd0);
        chk("rstw_req_low", {31'd0, reg_req_o}, 32'd0);
        @(negedge clk_i);
        chk("rstw_a_ready_after", {31'd0, tl_o.a_ready}, 32'd1);
        chk("rstw_d_valid_after", {31'd0, tl_o.d_valid}, 32'd0);
        txn(3'd4, 2'd2, 32'h0000_0034, 4'hF, 32'h0, 8'd11, 0, 0, 32'h0000_00A5, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
